sere64_serializer: RTL
======================

// Module: sere64_serializer
// PURPOSE
//   Transmit end of the sign-bit slice link: accepts 64-bit sign words plus valid-bit count and
//   streams them one bit per cycle on sign_out/sign_wr, then pulses slice_end after a slice's last word.
//   Output protocol is exactly what dese64 consumes; one-word holding buffer keeps the stream gapless.
// PARAMETERS
//   WIDTH   64  bits per word; must be a power of two
//   CNT_W   7   size field width; equals $clog2(WIDTH)+1
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   clk_en     in   1      global enable; no state changes when 0
//   word_in    in   WIDTH  [0:WIDTH-1]; bit 0 transmitted first
//   size_in    in   CNT_W  valid bits in word_in, 0..WIDTH; bits [size_in..] ignored
//   last_in    in   1      word closes the current slice
//   word_wr    in   1      upstream offers word; accepted when word_wr && word_rdy && clk_en
//   word_rdy   out  1      holding buffer empty
//   sign_stall in   1      downstream hold; freezes shifter, sign_wr forced 0
//   sign_out   out  1      current serial bit
//   sign_wr    out  1      sign_out valid this cycle
//   slice_end  out  1      one-cycle slice terminator
//   busy       out  1      any word buffered, shifting, or slice_end pending
// BEHAVIOUR
//   Reset: state IDLE, both buffers empty, counters 0; word_rdy=1, sign_out=0, sign_wr=0,
//     slice_end=0, busy=0. Reset mid-word discards all data; no slice_end emitted.
//   Storage: hold register (word, size, last, full flag) feeding shift register (word, remaining count, last).
//   Load: accept writes hold; hold moves to shifter on the cycle the shifter empties (or is IDLE).
//     Accept into empty IDLE pipe -> first sign_wr two cycles after accept (hold, then shift).
//   FSM, advancing only when clk_en=1:
//     IDLE  : hold full -> load shifter; size>0 -> SHIFT; size==0 && last -> END; size==0 && !last -> drop word, stay IDLE.
//     SHIFT : registered sign_wr=1 when !sign_stall, sign_out=shift[0]; shift left, remaining--.
//             remaining reaches 0: last -> END; else hold full -> reload same cycle, stay SHIFT
//             (gapless, next word's bit 0 follows directly); else IDLE.
//     END   : slice_end=1, sign_wr=0 for exactly one cycle -> IDLE, or reload SHIFT if hold full.
//   sign_stall: in SHIFT, sign_wr=0, shifter and count hold; slice_end is not delayed by stall.
//   clk_en=0: all registered outputs hold value; a high sign_wr stays high and is not re-counted
//     downstream (dese64 gates on clk_en).
//   word_wr while word_rdy=0: ignored, upstream must hold. Write on the cycle hold drains: accepted
//     (word_rdy is combinational on hold-empty OR hold-draining-this-cycle).
//   size_in > WIDTH: clamped to WIDTH. Count arithmetic width CNT_W, never wraps.
//   Word with last_in and size 0: emits slice_end only (empty slice).
// STRUCTURE
//   Shared package dese_pkg: WIDTH, CNT_W, typedef logic [0:WIDTH-1] sign_word_t,
//     typedef logic [CNT_W-1:0] sign_size_t, enum {IDLE, SHIFT, END} ser_state_t;
//     same package imported by dese64.
//   One sub-module: sere64_hold (holding register + full flag + word_rdy logic).
//   Shifter, counter, FSM stay in top.
// TESTING
//   Checker: loopback into dese64 plus bit scoreboard; every test also runs with clk_en toggling 1-of-3.
//   1 one word 0xAAAA_AAAA_AAAA_AAAA, size 64, last -> 64 cycles sign_wr, bits 1,0,1,0..., then 1 slice_end;
//     dese64 size_out=64.
//   2 two words back-to-back (size 64, 27; last on 2nd) -> 91 contiguous sign_wr, no gap; slice_end once
//     at cycle 92; dese64 outputs 64 then 27.
//   3 sign_stall high 5 cycles mid-word (after bit 10) -> sign_wr low exactly 5 cycles, bit 11 resumes,
//     no bit lost or duplicated.
//   4 size 0 with last -> slice_end alone, zero sign_wr; size 0 without last -> no output, word_rdy back next cycle.
//   5 word_wr held while hold full -> word_rdy=0, no overwrite; accepted cycle shifter reloads.
//   6 rst asserted at bit 30 -> next cycle all outputs 0, word_rdy=1; fresh word afterwards streams correctly.

Source files
------------

// File: rtl/dese_pkg.sv
// Shared definitions for the sign-bit slice link (serializer and deserializer sides).
// Word bit 0 is the first bit on the wire, hence the ascending word range.
package dese_pkg;

    localparam int WIDTH = 64;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef logic [0:WIDTH-1] sign_word_t;
    typedef logic [CNT_W-1:0] sign_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        END   = 2'd2
    } ser_state_t;

    localparam sign_size_t SIZE_MAX = sign_size_t'(WIDTH);
    localparam sign_size_t SIZE_ONE = sign_size_t'(1);

    // Oversized counts are treated as a full word.
    function automatic sign_size_t clamp_size(input sign_size_t s);
        return (s > SIZE_MAX) ? SIZE_MAX : s;
    endfunction

endpackage

// File: rtl/sere64_hold.sv
// One-word holding buffer in front of the shifter. Ready is asserted when empty or when
// the shifter takes the held word this cycle, so a new word can land without a bubble.
module sere64_hold
    import dese_pkg::*;
(
    input  logic             clk,
    input  logic             rst_i,
    input  logic             clk_en_i,
    input  logic [0:WIDTH-1] word_i,
    input  logic [CNT_W-1:0] size_i,
    input  logic             last_i,
    input  logic             wr_i,
    input  logic             drain_i,
    output logic             rdy_o,
    output logic             full_o,
    output logic [0:WIDTH-1] word_o,
    output logic [CNT_W-1:0] size_o,
    output logic             last_o
);

    logic       full_q, full_d;
    sign_word_t word_q, word_d;
    sign_size_t size_q, size_d;
    logic       last_q, last_d;
    logic       accept;

    always_comb begin
        rdy_o  = !full_q || drain_i;
        accept = wr_i && rdy_o && clk_en_i;
        full_d = full_q;
        word_d = word_q;
        size_d = size_q;
        last_d = last_q;
        if (accept) begin
            full_d = 1'b1;
            word_d = word_i;
            size_d = clamp_size(size_i);
            last_d = last_i;
        end else if (clk_en_i && drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            full_q <= 1'b0;
            word_q <= '0;
            size_q <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
            size_q <= size_d;
            last_q <= last_d;
        end
    end

    assign full_o = full_q;
    assign word_o = word_q;
    assign size_o = size_q;
    assign last_o = last_q;

endmodule

// File: rtl/sere64_serializer.sv
// Transmit side of the sign-bit slice link: streams buffered words one bit per cycle and
// closes each slice with a one-cycle slice_end pulse. All outputs are registered.
module sere64_serializer
    import dese_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [0:WIDTH-1] word_in,
    input  logic [CNT_W-1:0] size_in,
    input  logic             last_in,
    input  logic             word_wr,
    output logic             word_rdy,
    input  logic             sign_stall,
    output logic             sign_out,
    output logic             sign_wr,
    output logic             slice_end,
    output logic             busy
);

    ser_state_t state_q, state_d;
    sign_word_t shift_q, shift_d;
    sign_size_t rem_q, rem_d;
    logic       last_q, last_d;
    logic       sign_out_q, sign_out_d;
    logic       sign_wr_q, sign_wr_d;
    logic       slice_end_q, slice_end_d;

    logic       hold_full;
    sign_word_t hold_word;
    sign_size_t hold_size;
    logic       hold_last;
    logic       word_done;
    logic       drain;
    ser_state_t load_state;
    sign_word_t shift_adv;

    sere64_hold u_hold (
        .clk      (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .word_i   (word_in),
        .size_i   (size_in),
        .last_i   (last_in),
        .wr_i     (word_wr),
        .drain_i  (drain),
        .rdy_o    (word_rdy),
        .full_o   (hold_full),
        .word_o   (hold_word),
        .size_o   (hold_size),
        .last_o   (hold_last)
    );

    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
        assign shift_adv[gi] = shift_q[gi+1];
    end
    assign shift_adv[WIDTH-1] = 1'b0;

    // The shifter pulls the held word when idle, after a slice terminator, or on the
    // same edge that emits the final bit of a non-last word (keeps the stream gapless).
    assign word_done = (state_q == SHIFT) && !sign_stall && (rem_q == SIZE_ONE);
    assign drain     = hold_full && ((state_q == IDLE) || (state_q == END) ||
                                     (word_done && !last_q));

    always_comb begin
        load_state = IDLE;
        if (hold_size != '0) begin
            load_state = SHIFT;
        end else if (hold_last) begin
            load_state = END;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        last_d      = last_q;
        sign_out_d  = sign_out_q;
        sign_wr_d   = sign_wr_q;
        slice_end_d = slice_end_q;
        if (clk_en) begin
            sign_wr_d   = 1'b0;
            slice_end_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (drain) begin
                        state_d = load_state;
                    end
                end
                SHIFT: begin
                    if (!sign_stall) begin
                        sign_wr_d  = 1'b1;
                        sign_out_d = shift_q[0];
                        shift_d    = shift_adv;
                        rem_d      = rem_q - SIZE_ONE;
                        if (rem_q == SIZE_ONE) begin
                            if (last_q) begin
                                state_d = END;
                            end else if (drain) begin
                                state_d = load_state;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                END: begin
                    slice_end_d = 1'b1;
                    state_d     = drain ? load_state : IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (drain) begin
                shift_d = hold_word;
                rem_d   = hold_size;
                last_d  = hold_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            sign_out_q  <= 1'b0;
            sign_wr_q   <= 1'b0;
            slice_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
            sign_out_q  <= sign_out_d;
            sign_wr_q   <= sign_wr_d;
            slice_end_q <= slice_end_d;
        end
    end

    assign sign_out  = sign_out_q;
    assign sign_wr   = sign_wr_q;
    assign slice_end = slice_end_q;
    assign busy      = hold_full || (state_q != IDLE);

endmodule
